// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control sequencer.
//   - state_t    : sequencer state encoding (also exported on the debug port)
//   - OP_*       : primary opcode field values
//   - ALU_*      : alu_op encodings
//   - SRCB_*     : alu_src_b mux encodings
//   - PCS_*      : pc_source mux encodings
//   - iclass_t   : decoded instruction class, one-hot-ish flags
// Optional feature macro: MC_JAL_EN (enables the jal opcode / JAL state).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC      = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_TRAP      = 4'd12,
    S_JAL       = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCS_ALU  = 2'b00;
  localparam logic [1:0] PCS_OUT  = 2'b01;
  localparam logic [1:0] PCS_JUMP = 2'b10;

  typedef struct packed {
    logic r;
    logic lw;
    logic sw;
    logic br;       // beq or bne
    logic bne;      // qualifies br: invert the zero test
    logic j;
    logic jal;
    logic imm;      // I-type ALU op
    logic illegal;
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode classifier.
//   opcode     in  6  instruction [31:26]
//   cls        out    instruction class flags
//   imm_alu_op out 3  alu_op to use in I_EXEC for I-type ALU instructions
// With MC_JAL_EN undefined, the jal opcode is classified as illegal.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output iclass_t    cls,
  output logic [2:0] imm_alu_op
);

  always_comb begin
    cls        = '0;
    imm_alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: cls.r = 1'b1;
      OP_LW:    cls.lw = 1'b1;
      OP_SW:    cls.sw = 1'b1;
      OP_BEQ:   cls.br = 1'b1;
      OP_BNE:   begin cls.br = 1'b1; cls.bne = 1'b1; end
      OP_J:     cls.j = 1'b1;
      OP_ADDI:  cls.imm = 1'b1;
      OP_ANDI:  begin cls.imm = 1'b1; imm_alu_op = ALU_AND; end
      OP_ORI:   begin cls.imm = 1'b1; imm_alu_op = ALU_OR;  end
      OP_SLTI:  begin cls.imm = 1'b1; imm_alu_op = ALU_SLT; end
`ifdef MC_JAL_EN
      OP_JAL:   cls.jal = 1'b1;
`else
      OP_JAL:   cls.illegal = 1'b1;
`endif
      default:  cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control sequencer with memory wait states, stall timeout
// and sticky trap flags.
//   clk, rstb        clock (rising), async active-low reset
//   instr            IR contents; only the opcode drives sequencing
//   alu_zero         ALU zero flag (branch resolution)
//   mem_ready        memory completes the current access this cycle
//   pc_en..link      datapath controls (Moore, except pc_en/ir_write)
//   state            current state for debug
//   bus_error        sticky: memory stall timeout
//   illegal_instr    sticky: undefined opcode
// Optional feature macro: MC_JAL_EN (jal support via JAL state 13).
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        iord,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        link,
  output logic [3:0]  state,
  output logic        bus_error,
  output logic        illegal_instr
);

  // Trap fires on the cycle that would be the TIMEOUT_CYCLES-th stall.
  localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  stall_cnt, stall_d;
  iclass_t           cls;
  logic [2:0]        imm_alu_op;
  logic              mem_state, timeout;
  logic              pc_en_c, ir_write_c, reg_write_c, mem_wr_c;

  // Register/immediate fields are consumed by the datapath, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:0];

  mc_decode u_decode (
    .opcode     (instr[31:26]),
    .cls        (cls),
    .imm_alu_op (imm_alu_op)
  );

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                     (state_q == S_MEM_WRITE);
  // mem_ready wins over an expiring counter.
  assign timeout   = mem_state && !mem_ready && (stall_cnt == STALL_LIMIT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (cls.r)                state_d = S_EXEC;
        else if (cls.lw || cls.sw) state_d = S_MEM_ADDR;
        else if (cls.br)          state_d = S_BRANCH;
        else if (cls.j)           state_d = S_JUMP;
`ifdef MC_JAL_EN
        else if (cls.jal)         state_d = S_JAL;
`endif
        else if (cls.imm)         state_d = S_I_EXEC;
        else                      state_d = S_TRAP;
      end
      S_MEM_ADDR:  state_d = cls.sw ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC:      state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_I_EXEC:    state_d = S_I_WB;
      S_I_WB:      state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase
    if (timeout) state_d = S_TRAP;
  end

  // Counter only runs while sitting stalled in one memory state.
  always_comb begin
    stall_d = '0;
    if (mem_state && !mem_ready && (state_d == state_q))
      stall_d = stall_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q       <= S_FETCH;
      stall_cnt     <= '0;
      bus_error     <= 1'b0;
      illegal_instr <= 1'b0;
    end else begin
      state_q   <= state_d;
      stall_cnt <= stall_d;
      if (timeout) bus_error <= 1'b1;
      if ((state_q == S_DECODE) && (state_d == S_TRAP)) illegal_instr <= 1'b1;
    end
  end

  always_comb begin
    pc_en_c     = 1'b0;
    iord        = 1'b0;
    mem_rd      = 1'b0;
    mem_wr_c    = 1'b0;
    ir_write_c  = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write_c = 1'b0;
    reg_dst     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REGB;
    alu_op      = ALU_ADD;
    pc_source   = PCS_ALU;
    link        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd     = 1'b1;
        alu_src_b  = SRCB_FOUR;
        ir_write_c = mem_ready;
        pc_en_c    = mem_ready;
      end
      S_DECODE:    alu_src_b = SRCB_IMM2;
      S_MEM_ADDR:  begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; end
      S_MEM_READ:  begin mem_rd = 1'b1; iord = 1'b1; end
      S_MEM_WB:    begin reg_write_c = 1'b1; mem_to_reg = 1'b1; end
      S_MEM_WRITE: begin mem_wr_c = 1'b1; iord = 1'b1; end
      S_EXEC:      begin alu_src_a = 1'b1; alu_op = ALU_FUNCT; end
      S_R_WB:      begin reg_write_c = 1'b1; reg_dst = 1'b1; end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PCS_OUT;
        pc_en_c   = cls.bne ? !alu_zero : alu_zero;
      end
      S_JUMP:      begin pc_en_c = 1'b1; pc_source = PCS_JUMP; end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = imm_alu_op;
      end
      S_I_WB:      reg_write_c = 1'b1;
`ifdef MC_JAL_EN
      // PC already holds PC+4 here, which is the link value.
      S_JAL: begin
        pc_en_c     = 1'b1;
        pc_source   = PCS_JUMP;
        reg_write_c = 1'b1;
        link        = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Architectural enables are held off for the whole reset pulse.
  assign pc_en     = pc_en_c     & rstb;
  assign ir_write  = ir_write_c  & rstb;
  assign reg_write = reg_write_c & rstb;
  assign mem_wr    = mem_wr_c    & rstb;
  assign state     = state_q;

endmodule
